// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types, constants and helpers for the UART transmit path
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_DATA = 2'd2,
        ST_STOP = 2'd3
    } state_t;

    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;
    localparam logic LINE_STOP  = 1'b1;

    function automatic int gw_calc(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_tx_sched_if.sv
// rtl/uart_tx_sched_if.sv - requester handshake and serial line bundle for uart_tx_sched
interface uart_tx_sched_if #(
    parameter int NREQ   = 2,
    parameter int DWIDTH = 8,
    parameter int GW     = uart_pkg::gw_calc(NREQ)
);
    logic [NREQ-1:0]        i_req_valid;
    logic [NREQ*DWIDTH-1:0] i_req_data;
    logic [NREQ-1:0]        o_req_ready;
    logic [GW-1:0]          o_grant;
    logic                   o_busy;
    logic                   o_done;
    logic                   ot_tx;

    modport master (
        output i_req_valid, i_req_data,
        input  o_req_ready, o_grant, o_busy, o_done, ot_tx
    );

    modport slave (
        input  i_req_valid, i_req_data,
        output o_req_ready, o_grant, o_busy, o_done, ot_tx
    );
endinterface

// File: rtl/uart_rr_arbiter.sv
// rtl/uart_rr_arbiter.sv - combinational round-robin pick, first request above ptr with wrap
module uart_rr_arbiter #(
    parameter int NREQ = 2,
    parameter int GW   = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [GW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [GW-1:0]   idx,
    output logic            any
);
    always_comb begin
        idx   = '0;
        any   = 1'b0;
        grant = '0;
        // Lowest overall request is the wrap-around fallback; a request above ptr overrides it.
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[GW'(i)]) begin
                idx = GW'(i);
                any = 1'b1;
            end
        end
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[GW'(i)] && (GW'(i) > ptr)) begin
                idx = GW'(i);
            end
        end
        if (any) begin
            grant[idx] = 1'b1;
        end
    end
endmodule

// File: rtl/uart_tx_sched.sv
// rtl/uart_tx_sched.sv - round-robin shared UART transmitter, start + DWIDTH LSB-first + stop bits
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int NREQ      = 2,
    parameter int DWIDTH    = 8,
    parameter int STOP_BITS = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           baud_en,
    uart_tx_sched_if.slave bus
);
    localparam int GW = gw_calc(NREQ);
    localparam int BW = $clog2(DWIDTH + 1);

    state_t            state;
    logic [DWIDTH-1:0] shreg;
    logic [BW-1:0]     bit_cnt;
    logic [1:0]        stop_cnt;
    logic              tx_q;
    logic              busy_q;
    logic              done_q;
    logic [GW-1:0]     grant_q;
    logic [GW-1:0]     ptr;

    logic [NREQ-1:0]   win_onehot;
    logic [GW-1:0]     win_idx;
    logic              win_any;
    logic [DWIDTH-1:0] win_data;

    uart_rr_arbiter #(
        .NREQ (NREQ),
        .GW   (GW)
    ) u_arb (
        .req   (bus.i_req_valid),
        .ptr   (ptr),
        .grant (win_onehot),
        .idx   (win_idx),
        .any   (win_any)
    );

    assign win_data = bus.i_req_data[32'(win_idx) * DWIDTH +: DWIDTH];

    // Acceptance is Mealy so a requester sees ready in the same cycle it is chosen.
    assign bus.o_req_ready = (state == ST_IDLE && !rst) ? win_onehot : '0;
    assign bus.o_grant     = grant_q;
    assign bus.o_busy      = busy_q;
    assign bus.o_done      = done_q;
    assign bus.ot_tx       = tx_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            shreg    <= '0;
            bit_cnt  <= '0;
            stop_cnt <= '0;
            tx_q     <= LINE_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            grant_q  <= '0;
            ptr      <= GW'(NREQ - 1);
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    tx_q <= LINE_IDLE;
                    if (win_any) begin
                        shreg   <= win_data;
                        grant_q <= win_idx;
                        ptr     <= win_idx;
                        busy_q  <= 1'b1;
                        state   <= ST_SYNC;
                    end
                end
                ST_SYNC: begin
                    if (baud_en) begin
                        tx_q    <= LINE_START;
                        bit_cnt <= '0;
                        state   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (baud_en) begin
                        tx_q    <= shreg[0];
                        shreg   <= shreg >> 1;
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == BW'(DWIDTH - 1)) begin
                            stop_cnt <= '0;
                            state    <= ST_STOP;
                        end
                    end
                end
                ST_STOP: begin
                    // stop_cnt counts stop periods already started; the frame ends once all are complete.
                    if (baud_en) begin
                        if (stop_cnt == 2'(STOP_BITS)) begin
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                            state  <= ST_IDLE;
                        end else begin
                            tx_q     <= LINE_STOP;
                            stop_cnt <= stop_cnt + 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_sched.sv
// tb/tb_uart_tx_sched.sv - directed self-checking bench for uart_tx_sched
module tb_uart_tx_sched;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic baud_en = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int sel = 0;

    uart_tx_sched_if #(.NREQ(2), .DWIDTH(8)) a_if ();
    uart_tx_sched_if #(.NREQ(3), .DWIDTH(8)) b_if ();
    uart_tx_sched_if #(.NREQ(2), .DWIDTH(8)) c_if ();

    uart_tx_sched #(.NREQ(2), .DWIDTH(8), .STOP_BITS(1)) dut_a (
        .clk(clk), .rst(rst), .baud_en(baud_en), .bus(a_if));
    uart_tx_sched #(.NREQ(3), .DWIDTH(8), .STOP_BITS(1)) dut_b (
        .clk(clk), .rst(rst), .baud_en(baud_en), .bus(b_if));
    uart_tx_sched #(.NREQ(2), .DWIDTH(8), .STOP_BITS(2)) dut_c (
        .clk(clk), .rst(rst), .baud_en(baud_en), .bus(c_if));

    logic       tx_m, done_m, busy_m;
    logic [1:0] grant_m;
    logic [2:0] ready_m;

    always_comb begin
        tx_m = 1'b1; done_m = 1'b0; busy_m = 1'b0; grant_m = '0; ready_m = '0;
        case (sel)
            0: begin tx_m = a_if.ot_tx; done_m = a_if.o_done; busy_m = a_if.o_busy;
                     grant_m = {1'b0, a_if.o_grant}; ready_m = {1'b0, a_if.o_req_ready}; end
            1: begin tx_m = b_if.ot_tx; done_m = b_if.o_done; busy_m = b_if.o_busy;
                     grant_m = b_if.o_grant; ready_m = b_if.o_req_ready; end
            default: begin tx_m = c_if.ot_tx; done_m = c_if.o_done; busy_m = c_if.o_busy;
                     grant_m = {1'b0, c_if.o_grant}; ready_m = {1'b0, c_if.o_req_ready}; end
        endcase
    end

    logic [15:0] line;
    int          done_at;

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic baud_tick();
        repeat (3) @(negedge clk);
        baud_en = 1'b1;
        @(negedge clk);
        baud_en = 1'b0;
    endtask

    task automatic run_frame(input int n, output logic [15:0] ln, output int dat);
        ln  = '1;
        dat = 0;
        for (int t = 1; t <= n; t++) begin
            baud_tick();
            ln[4'(t - 1)] = tx_m;
            if (done_m && dat == 0) dat = t;
        end
    endtask

    task automatic test_reset();
        sel = 0;
        rst = 1'b1;
        a_if.i_req_valid = 2'b01;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (a_if.ot_tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", a_if.ot_tx); end
        checks++; if (a_if.o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", a_if.o_busy); end
        checks++; if (a_if.o_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", a_if.o_done); end
        checks++; if (a_if.o_grant !== 1'b0) begin errors++; $display("FAIL reset_grant: got %0d want 0", a_if.o_grant); end
        checks++; if (a_if.o_req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b want 00", a_if.o_req_ready); end
        a_if.i_req_valid = 2'b00;
        rst = 1'b0;
    endtask

    task automatic test_single_frame();
        sel = 0;
        do_reset();
        a_if.i_req_data  = 16'h00A5;
        a_if.i_req_valid = 2'b01;
        #1;
        checks++; if (ready_m[1:0] !== 2'b01) begin errors++; $display("FAIL single_ready: got %b want 01", ready_m[1:0]); end
        @(negedge clk);
        a_if.i_req_valid = 2'b00;
        a_if.i_req_data  = 16'h0000;
        #1;
        checks++; if (busy_m !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", busy_m); end
        checks++; if (ready_m[1:0] !== 2'b00) begin errors++; $display("FAIL single_ready_drop: got %b want 00", ready_m[1:0]); end
        checks++; if (tx_m !== 1'b1) begin errors++; $display("FAIL single_idle_line: got %b want 1", tx_m); end
        run_frame(11, line, done_at);
        checks++; if (line[10:0] !== {2'b11, 8'hA5, 1'b0}) begin errors++; $display("FAIL single_line: got %b want %b", line[10:0], {2'b11, 8'hA5, 1'b0}); end
        checks++; if (done_at !== 11) begin errors++; $display("FAIL single_done_tick: got %0d want 11", done_at); end
        checks++; if (busy_m !== 1'b0) begin errors++; $display("FAIL single_busy_end: got %b want 0", busy_m); end
        @(negedge clk);
        checks++; if (done_m !== 1'b0) begin errors++; $display("FAIL single_done_pulse: got %b want 0", done_m); end
    endtask

    task automatic test_alternate();
        logic [7:0] exp_byte;
        int         exp_g;
        sel = 0;
        do_reset();
        a_if.i_req_data  = {8'h22, 8'h11};
        a_if.i_req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            exp_g    = k % 2;
            exp_byte = (exp_g == 1) ? 8'h22 : 8'h11;
            #1;
            checks++; if (ready_m[1:0] !== ((exp_g == 1) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL alt_ready%0d: got %b want grant %0d", k, ready_m[1:0], exp_g); end
            @(negedge clk);
            checks++; if (grant_m !== 2'(exp_g)) begin errors++; $display("FAIL alt_grant%0d: got %0d want %0d", k, grant_m, exp_g); end
            run_frame(11, line, done_at);
            checks++; if (line[8:1] !== exp_byte) begin errors++; $display("FAIL alt_byte%0d: got %h want %h", k, line[8:1], exp_byte); end
            checks++; if (done_at !== 11) begin errors++; $display("FAIL alt_done%0d: got %0d want 11", k, done_at); end
        end
        a_if.i_req_valid = 2'b00;
    endtask

    task automatic test_three_sparse();
        logic [7:0] exp_byte;
        int         exp_g;
        sel = 1;
        do_reset();
        b_if.i_req_data  = {8'hC3, 8'h55, 8'h3C};
        b_if.i_req_valid = 3'b101;
        for (int k = 0; k < 4; k++) begin
            exp_g    = (k % 2 == 1) ? 2 : 0;
            exp_byte = (exp_g == 2) ? 8'hC3 : 8'h3C;
            #1;
            checks++; if (ready_m !== ((exp_g == 2) ? 3'b100 : 3'b001)) begin errors++; $display("FAIL three_ready%0d: got %b want grant %0d", k, ready_m, exp_g); end
            @(negedge clk);
            checks++; if (grant_m !== 2'(exp_g)) begin errors++; $display("FAIL three_grant%0d: got %0d want %0d", k, grant_m, exp_g); end
            run_frame(11, line, done_at);
            checks++; if (line[8:1] !== exp_byte) begin errors++; $display("FAIL three_byte%0d: got %h want %h", k, line[8:1], exp_byte); end
            checks++; if (done_at !== 11) begin errors++; $display("FAIL three_done%0d: got %0d want 11", k, done_at); end
        end
        b_if.i_req_valid = 3'b000;
    endtask

    task automatic test_coincident_baud();
        sel = 0;
        do_reset();
        a_if.i_req_data  = 16'h005A;
        a_if.i_req_valid = 2'b01;
        baud_en = 1'b1;
        @(negedge clk);
        baud_en = 1'b0;
        a_if.i_req_valid = 2'b00;
        checks++; if (busy_m !== 1'b1) begin errors++; $display("FAIL coin_busy: got %b want 1", busy_m); end
        checks++; if (tx_m !== 1'b1) begin errors++; $display("FAIL coin_no_start: got %b want 1", tx_m); end
        run_frame(11, line, done_at);
        checks++; if (line[10:0] !== {2'b11, 8'h5A, 1'b0}) begin errors++; $display("FAIL coin_line: got %b want %b", line[10:0], {2'b11, 8'h5A, 1'b0}); end
        checks++; if (done_at !== 11) begin errors++; $display("FAIL coin_done_tick: got %0d want 11", done_at); end
    endtask

    task automatic test_reset_mid_frame();
        sel = 0;
        do_reset();
        a_if.i_req_data  = 16'h0000;
        a_if.i_req_valid = 2'b01;
        @(negedge clk);
        a_if.i_req_valid = 2'b00;
        run_frame(5, line, done_at);
        checks++; if (tx_m !== 1'b0) begin errors++; $display("FAIL mid_line_low: got %b want 0", tx_m); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (tx_m !== 1'b1) begin errors++; $display("FAIL mid_tx: got %b want 1", tx_m); end
        checks++; if (busy_m !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b want 0", busy_m); end
        checks++; if (done_m !== 1'b0) begin errors++; $display("FAIL mid_done: got %b want 0", done_m); end
        a_if.i_req_valid = 2'b11;
        #1;
        checks++; if (ready_m[1:0] !== 2'b01) begin errors++; $display("FAIL mid_ready: got %b want 01", ready_m[1:0]); end
        @(negedge clk);
        a_if.i_req_valid = 2'b00;
        checks++; if (grant_m !== 2'd0) begin errors++; $display("FAIL mid_grant: got %0d want 0", grant_m); end
    endtask

    task automatic test_two_stop();
        sel = 2;
        do_reset();
        c_if.i_req_data  = 16'h00FF;
        c_if.i_req_valid = 2'b01;
        @(negedge clk);
        c_if.i_req_valid = 2'b00;
        run_frame(12, line, done_at);
        checks++; if (line[11:0] !== {3'b111, 8'hFF, 1'b0}) begin errors++; $display("FAIL stop2_line: got %b want %b", line[11:0], {3'b111, 8'hFF, 1'b0}); end
        checks++; if (done_at !== 12) begin errors++; $display("FAIL stop2_done_tick: got %0d want 12", done_at); end
        checks++; if (busy_m !== 1'b0) begin errors++; $display("FAIL stop2_busy: got %b want 0", busy_m); end
    endtask

    initial begin
        a_if.i_req_valid = '0; a_if.i_req_data = '0;
        b_if.i_req_valid = '0; b_if.i_req_data = '0;
        c_if.i_req_valid = '0; c_if.i_req_data = '0;
        test_reset();
        test_single_frame();
        test_alternate();
        test_three_sparse();
        test_coincident_baud();
        test_reset_mid_frame();
        test_two_stop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
